// File: rtl/imem_loader_if.sv
// imem_loader_if: start/byte-stream/instruction-memory bundle between a host and the loader.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed little-endian byte stream into instruction memory.
module imem_loader #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst_n,
  imem_loader_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;
  localparam logic [16:0] DEPTH = 17'(DEPTH_WORDS);
  logic [2:0]  state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word;
  logic [15:0] len;
  logic [15:0] next_idx;
  assign len          = {bus.in_data, count[7:0]};
  assign next_idx     = word_idx + 16'd1;
  assign bus.in_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign bus.mem_we   = state == WRITE;
  assign bus.done     = state == DONE;
  // Lanes 0..2 shift in from the top so the word register always holds them in order when lane 3 arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      word          <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_hold  <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state        <= LEN0;
          bus.cpu_hold <= 1'b1;
          bus.err      <= 1'b0;
        end
        LEN0: if (bus.in_valid) begin
          count[7:0] <= bus.in_data;
          state      <= LEN1;
        end
        LEN1: if (bus.in_valid) begin
          count[15:8] <= bus.in_data;
          byte_idx    <= '0;
          word_idx    <= '0;
          state       <= (len == 16'd0) ? DONE : ({1'b0, len} > DEPTH) ? ERR : DATA;
        end
        DATA: if (bus.in_valid) begin
          word     <= {bus.in_data, word[23:8]};
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            bus.mem_wdata <= {bus.in_data, word};
            bus.mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
            state         <= WRITE;
          end
        end
        WRITE: begin
          word_idx <= next_idx;
          state    <= (next_idx == count) ? DONE : DATA;
        end
        DONE: begin
          bus.cpu_hold <= 1'b0;
          state        <= IDLE;
        end
        ERR: begin
          bus.err      <= 1'b1;
          bus.cpu_hold <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of two loaders (base 0 and base 0x100) fed the same byte stream.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int wr_n = 0;
  int w1_n = 0;
  int ready_bad = 0;
  logic [31:0] wa [8];
  logic [31:0] wd [8];
  logic [31:0] w1_first = '0;
  imem_loader_if b0 ();
  imem_loader_if b1 ();
  assign b1.start    = b0.start;
  assign b1.in_valid = b0.in_valid;
  assign b1.in_data  = b0.in_data;
  imem_loader #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  imem_loader #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h100)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (b0.mem_we) begin
      if (wr_n < 8) begin
        wa[wr_n] = b0.mem_addr;
        wd[wr_n] = b0.mem_wdata;
      end
      wr_n++;
      if (b0.in_ready) ready_bad++;
    end
    if (b1.mem_we) begin
      if (w1_n == 0) w1_first = b1.mem_addr;
      w1_n++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    while (!b0.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("in_ready_wait", {31'd0, b0.in_ready}, 32'd1);
    b0.in_valid = 1'b1;
    b0.in_data  = d;
    @(negedge clk);
    b0.in_valid = 1'b0;
  endtask
  task automatic pulse_start();
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!b0.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, b0.done}, 32'd1);
    @(negedge clk);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, b0.in_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, b0.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, b0.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, b0.mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, b0.cpu_hold}, 32'd0);
    chk({tag, "_done"}, {31'd0, b0.done}, 32'd0);
    chk({tag, "_err"}, {31'd0, b0.err}, 32'd0);
    chk({tag, "_b1_mem_addr"}, b1.mem_addr, 32'd0);
  endtask
  initial begin
    logic [7:0] d31 [12];
    d31 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hde, 8'had, 8'hbe, 8'hef, 8'h01, 8'h02, 8'h03, 8'h04};
    b0.start = 1'b0;
    b0.in_valid = 1'b0;
    b0.in_data = 8'h00;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // single word session
    pulse_start();
    chk("s1_cpu_hold", {31'd0, b0.cpu_hold}, 32'd1);
    chk("s1_in_ready_len0", {31'd0, b0.in_ready}, 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    chk("s1_mem_we", {31'd0, b0.mem_we}, 32'd1);
    chk("s1_mem_addr", b0.mem_addr, 32'h0);
    chk("s1_mem_wdata", b0.mem_wdata, 32'h2000_0013);
    chk("s1_in_ready_write", {31'd0, b0.in_ready}, 32'd0);
    chk("s1_b1_mem_addr", b1.mem_addr, 32'h100);
    @(negedge clk);
    chk("s1_done", {31'd0, b0.done}, 32'd1);
    chk("s1_mem_we_off", {31'd0, b0.mem_we}, 32'd0);
    chk("s1_wdata_hold", b0.mem_wdata, 32'h2000_0013);
    @(negedge clk);
    chk("s1_done_off", {31'd0, b0.done}, 32'd0);
    chk("s1_cpu_hold_off", {31'd0, b0.cpu_hold}, 32'd0);
    chk("s1_err", {31'd0, b0.err}, 32'd0);
    chk("s1_writes", wr_n, 1);
    // three words with random stalls
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(d31[i]);
    end
    wait_done();
    chk("s2_writes", wr_n, 4);
    chk("s2_addr0", wa[1], 32'h0);
    chk("s2_addr1", wa[2], 32'h4);
    chk("s2_addr2", wa[3], 32'h8);
    chk("s2_data0", wd[1], 32'h4433_2211);
    chk("s2_data1", wd[2], 32'hefbe_adde);
    chk("s2_data2", wd[3], 32'h0403_0201);
    chk("s2_ready_during_write", ready_bad, 0);
    chk("s2_cpu_hold_off", {31'd0, b0.cpu_hold}, 32'd0);
    // length 1025 is an error
    pulse_start();
    send_byte(8'h01); send_byte(8'h04);
    @(negedge clk);
    chk("s3_err", {31'd0, b0.err}, 32'd1);
    chk("s3_cpu_hold", {31'd0, b0.cpu_hold}, 32'd0);
    chk("s3_writes", wr_n, 4);
    pulse_start();
    chk("s3_err_cleared", {31'd0, b0.err}, 32'd0);
    chk("s3_cpu_hold_on", {31'd0, b0.cpu_hold}, 32'd1);
    // zero length completes without writing
    send_byte(8'h00); send_byte(8'h00);
    chk("s4_done", {31'd0, b0.done}, 32'd1);
    chk("s4_err", {31'd0, b0.err}, 32'd0);
    @(negedge clk);
    chk("s4_writes", wr_n, 4);
    // reset mid-word
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'haa); send_byte(8'hbb);
    chk("s5_cpu_hold_pre", {31'd0, b0.cpu_hold}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("s5_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("s5_idle_ready", {31'd0, b0.in_ready}, 32'd0);
    chk("s5_writes", wr_n, 4);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    chk("s5_mem_we", {31'd0, b0.mem_we}, 32'd1);
    chk("s5_mem_addr", b0.mem_addr, 32'h0);
    chk("s5_mem_wdata", b0.mem_wdata, 32'h1234_5678);
    wait_done();
    chk("s5_writes_after", wr_n, 5);
    // full depth
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] iw;
      iw = 16'(i);
      send_byte(iw[7:0]); send_byte(iw[15:8]); send_byte(8'ha5); send_byte(8'h5a);
    end
    chk("s6_last_addr0", b0.mem_addr, 32'h0000_0ffc);
    chk("s6_last_addr1", b1.mem_addr, 32'h0000_10fc);
    chk("s6_last_data1", b1.mem_wdata, 32'h5aa5_03ff);
    @(negedge clk);
    chk("s6_done0", {31'd0, b0.done}, 32'd1);
    chk("s6_done1", {31'd0, b1.done}, 32'd1);
    chk("s6_writes0", wr_n, 1029);
    chk("s6_writes1", w1_n, 1029);
    chk("s6_b1_first", w1_first, 32'h100);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
